sam_tx_line: RTL and testbench

- Upstream line driver for the SAM encoder. Latches a key (n, d, N) and a message word, then serialises them onto the two-wire `mode`/`str` link the encoder samples.
- Transmission has two parts: a configuration burst with `mode` high, then the pulse-width-coded message bits with `mode` low.
- Exactly one complete configuration plus one message is sent per `start` request.

---
 rtl/sam_tx_line.sv | 187 ++++++++++++++++++
 tb/tb_sam_tx_line.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sam_tx_line.sv
// SAM encoder line driver: latches a key and message, then sends a configuration burst and pulse-width-coded bits.
// Optional SAM_TX_KEY_CHECK_EN rejects key_n > 4 with an err pulse; otherwise key_n saturates to 4.
module sam_tx_line #(
  parameter int T_LONG  = 12,
  parameter int T_SHORT = 4,
  parameter int GUARD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  key_n,
  input  logic [15:0] key_d,
  input  logic [15:0] key_cap_n,
  input  logic [15:0] msg,
  output logic        mode,
  output logic        str,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CFG_N, S_CFG_D, S_CFG_CN,
    S_GUARD, S_BIT_HI, S_BIT_LO, S_TERM, S_DONE
  } state_t;

  localparam logic [5:0] TL_M1    = 6'(T_LONG - 1);
  localparam logic [5:0] TS_M1    = 6'(T_SHORT - 1);
  localparam logic [5:0] GUARD_M1 = 6'(GUARD - 1);

  state_t      state_q, state_d;
  logic [5:0]  phase_q, phase_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic [3:0]  keyN_q, keyN_d;
  logic [15:0] dKey_q, dKey_d, capN_q, capN_d, msg_q, msg_d;
  logic        mode_q, mode_d, str_q, str_d, busy_q, busy_d, done_q, done_d;
  logic        keyBad, keyReject, canStart;
  logic [4:0]  lenM1;

  assign keyBad   = key_n > 4'd4;
  assign lenM1    = (5'd1 << keyN_q) - 5'd1;
  assign canStart = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef SAM_TX_KEY_CHECK_EN
  logic rejPend_q, err_q;
  assign keyReject = keyBad;

  // Reject is flagged at the start edge and surfaces as err one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rejPend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rejPend_q <= canStart && start && keyBad;
      err_q     <= rejPend_q;
    end
  end
  assign err = err_q;
`else
  assign keyReject = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitCnt_d = bitCnt_q;
    keyN_d   = keyN_q;
    dKey_d   = dKey_q;
    capN_d   = capN_q;
    msg_d    = msg_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        phase_d = 6'd0;
        if (start && !keyReject) begin
          state_d = S_LOAD;
          keyN_d  = keyBad ? 4'd4 : key_n;
          dKey_d  = key_d;
          capN_d  = key_cap_n;
          msg_d   = msg;
        end
      end
      S_LOAD: begin
        state_d = S_CFG_N;
        phase_d = 6'd3;
      end
      S_CFG_N, S_CFG_D, S_CFG_CN: begin
        if (phase_q != 6'd0) begin
          phase_d = phase_q - 6'd1;
        end else if (state_q == S_CFG_CN) begin
          state_d = S_GUARD;
          phase_d = GUARD_M1;
        end else begin
          state_d = (state_q == S_CFG_N) ? S_CFG_D : S_CFG_CN;
          phase_d = {1'b0, lenM1};
        end
      end
      S_GUARD: begin
        if (phase_q != 6'd0) begin
          phase_d = phase_q - 6'd1;
        end else begin
          state_d  = S_BIT_HI;
          bitCnt_d = lenM1;
          phase_d  = msg_q[bitCnt_d[3:0]] ? TL_M1 : TS_M1;
        end
      end
      S_BIT_HI: begin
        if (phase_q != 6'd0) begin
          phase_d = phase_q - 6'd1;
        end else begin
          state_d = S_BIT_LO;
          phase_d = msg_q[bitCnt_q[3:0]] ? TS_M1 : TL_M1;
        end
      end
      S_BIT_LO: begin
        if (phase_q != 6'd0) begin
          phase_d = phase_q - 6'd1;
        end else if (bitCnt_q == 5'd0) begin
          state_d = S_TERM;
          phase_d = 6'd0;
        end else begin
          state_d  = S_BIT_HI;
          bitCnt_d = bitCnt_q - 5'd1;
          phase_d  = msg_q[bitCnt_d[3:0]] ? TL_M1 : TS_M1;
        end
      end
      S_TERM: begin
        state_d = S_DONE;
        phase_d = 6'd0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 6'd0;
      end
    endcase
  end

  // Outputs are decoded from the state being entered so they change on the same edge as the FSM.
  always_comb begin
    mode_d = state_d inside {S_CFG_N, S_CFG_D, S_CFG_CN};
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = state_d == S_DONE;
    str_d  = 1'b0;
    unique case (state_d)
      S_CFG_N:          str_d = keyN_q[phase_d[1:0]];
      S_CFG_D:          str_d = dKey_q[phase_d[3:0]];
      S_CFG_CN:         str_d = capN_q[phase_d[3:0]];
      S_BIT_HI, S_TERM: str_d = 1'b1;
      default:          str_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 6'd0;
      bitCnt_q <= 5'd0;
      keyN_q   <= 4'd0;
      dKey_q   <= 16'd0;
      capN_q   <= 16'd0;
      msg_q    <= 16'd0;
      mode_q   <= 1'b0;
      str_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitCnt_q <= bitCnt_d;
      keyN_q   <= keyN_d;
      dKey_q   <= dKey_d;
      capN_q   <= capN_d;
      msg_q    <= msg_d;
      mode_q   <= mode_d;
      str_q    <= str_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mode = mode_q;
  assign str  = str_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sam_tx_line.sv
// Directed bench for sam_tx_line: table of transfers checked cycle by cycle, plus back-to-back, reset and key-check sequences.
module tb_sam_tx_line;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [3:0]  keyN;
  logic [15:0] keyD, keyCapN, msgIn;
  logic        mode1, str1, busy1, done1, err1;
  logic        mode2, str2, busy2, done2, err2;

  always #5 clk = ~clk;

  sam_tx_line dut1 (
    .clk(clk), .reset(reset), .start(start1), .key_n(keyN), .key_d(keyD),
    .key_cap_n(keyCapN), .msg(msgIn), .mode(mode1), .str(str1), .busy(busy1),
    .done(done1), .err(err1)
  );

  sam_tx_line #(.T_LONG(6), .T_SHORT(4), .GUARD(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .key_n(keyN), .key_d(keyD),
    .key_cap_n(keyCapN), .msg(msgIn), .mode(mode2), .str(str2), .busy(busy2),
    .done(done2), .err(err2)
  );

  typedef struct {
    int          sel;
    logic [3:0]  n;
    logic [15:0] d;
    logic [15:0] cn;
    logic [15:0] msg;
    int          tl;
    int          ts;
    int          guard;
    int          expDone;
    int          expModeHigh;
    int          expCc;
    logic [15:0] expMsgcd;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one transfer; disturb pulses start mid-transfer, abortAt>0 pulls reset at that cycle.
  task automatic applyStimulus(input vec_t v, input bit disturb, input int abortAt);
    logic [3:0]  nSat;
    int          len, doneAt, streamErr, modeHigh, cc, hiLen, loLen, doneSeen;
    bit          em[$], es[$], cfg[$];
    bit          m, s, b, dn, e, prevS, haveSym, cfgOver;
    logic [15:0] mDec, dDec, nDec, msgcd;
    logic [3:0]  nDecV;
    int          lDec;

    nSat = (v.n > 4'd4) ? 4'd4 : v.n;
    len  = 1 << nSat;
    for (int i = 3; i >= 0; i--) begin em.push_back(1'b1); es.push_back(nSat[i]); end
    for (int i = len - 1; i >= 0; i--) begin em.push_back(1'b1); es.push_back(v.d[i]); end
    for (int i = len - 1; i >= 0; i--) begin em.push_back(1'b1); es.push_back(v.cn[i]); end
    for (int i = 0; i < v.guard; i++) begin em.push_back(1'b0); es.push_back(1'b0); end
    for (int i = len - 1; i >= 0; i--) begin
      for (int j = 0; j < (v.msg[i] ? v.tl : v.ts); j++) begin em.push_back(1'b0); es.push_back(1'b1); end
      for (int j = 0; j < (v.msg[i] ? v.ts : v.tl); j++) begin em.push_back(1'b0); es.push_back(1'b0); end
    end
    em.push_back(1'b0); es.push_back(1'b1);

    @(negedge clk);
    keyN = v.n; keyD = v.d; keyCapN = v.cn; msgIn = v.msg;
    if (v.sel == 1) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_at_start", v.sel == 1 ? busy2 : busy1, 1);
    start1 = 1'b0; start2 = 1'b0;
    keyN = ~keyN; keyD = ~keyD; keyCapN = ~keyCapN; msgIn = ~msgIn;

    doneAt = -1; streamErr = 0; modeHigh = 0; cc = 0; hiLen = 0; loLen = 0;
    prevS = 0; haveSym = 0; cfgOver = 0; mDec = 0;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      m  = v.sel == 1 ? mode2 : mode1;
      s  = v.sel == 1 ? str2  : str1;
      b  = v.sel == 1 ? busy2 : busy1;
      dn = v.sel == 1 ? done2 : done1;
      e  = v.sel == 1 ? err2  : err1;
      if (disturb && (c == 9 || c == 49)) begin keyN = 4'd0; start1 = 1'b1; end
      if (disturb && (c == 10 || c == 50)) start1 = 1'b0;
      if (abortAt > 0 && c == abortAt) begin
        reset = 1'b0; #1;
        checkOutput("abort_mode", v.sel == 1 ? mode2 : mode1, 0);
        checkOutput("abort_str",  v.sel == 1 ? str2  : str1,  0);
        checkOutput("abort_busy", v.sel == 1 ? busy2 : busy1, 0);
        doneSeen = 0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          if ((v.sel == 1 ? done2 : done1) !== 1'b0) doneSeen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          if ((v.sel == 1 ? done2 : done1) !== 1'b0) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        return;
      end
      if (c <= em.size()) begin
        if (m !== em[c-1] || s !== es[c-1] || b !== 1'b1 || dn !== 1'b0) streamErr++;
      end else if (c == em.size() + 1) begin
        if (m !== 1'b0 || s !== 1'b0 || b !== 1'b0 || dn !== 1'b1) streamErr++;
      end
      if (e !== 1'b0) streamErr++;
      if (m) begin
        modeHigh++;
        cfg.push_back(s);
      end else begin
        cfgOver = 1;
      end
      if (cfgOver && !m) begin
        if (s && !prevS) begin
          if (haveSym) begin
            mDec = {mDec[14:0], (hiLen > loLen) ? 1'b1 : 1'b0};
            cc++;
          end
          haveSym = 1; hiLen = 0; loLen = 0;
        end
        if (haveSym) begin
          if (s) hiLen++; else loLen++;
        end
        prevS = s;
      end
      if (dn === 1'b1) begin
        doneAt = c;
        break;
      end
    end

    msgcd = 16'hFFFF;
    if (cfg.size() >= 4) begin
      nDecV = {cfg[0], cfg[1], cfg[2], cfg[3]};
      lDec  = (nDecV > 4'd4) ? 0 : (1 << nDecV);
      if (lDec > 0 && cfg.size() >= 4 + 2 * lDec) begin
        dDec = 0; nDec = 0;
        for (int i = 0; i < lDec; i++) begin
          dDec = {dDec[14:0], cfg[4 + i]};
          nDec = {nDec[14:0], cfg[4 + lDec + i]};
        end
        msgcd = (mDec ^ dDec) | nDec;
      end
    end

    checkOutput("done_cycle", doneAt, v.expDone);
    checkOutput("stream_errors", streamErr, 0);
    checkOutput("mode_high_cycles", modeHigh, v.expModeHigh);
    checkOutput("encoder_cc", cc, v.expCc);
    checkOutput("encoder_msgcd", msgcd, v.expMsgcd);
  endtask

  initial begin
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0;
    keyN = 4'd0; keyD = 16'd0; keyCapN = 16'd0; msgIn = 16'd0;

    vecs.push_back('{0, 4'd2, 16'h000A, 16'h0001, 16'h0006, 12, 4, 4,  82, 12,  4, 16'h000D});
    vecs.push_back('{0, 4'd0, 16'h0000, 16'h0000, 16'h0001, 12, 4, 4,  28,  6,  1, 16'h0001});
    vecs.push_back('{0, 4'd4, 16'hFFFF, 16'h0000, 16'h1234, 12, 4, 4, 298, 36, 16, 16'hEDCB});
    vecs.push_back('{0, 4'd3, 16'h00F0, 16'h0081, 16'h00A5, 12, 4, 4, 154, 20,  8, 16'h00D5});
    vecs.push_back('{0, 4'd1, 16'h0002, 16'h0001, 16'hFFF1, 12, 4, 4,  46,  8,  2, 16'h0003});
`ifndef SAM_TX_KEY_CHECK_EN
    vecs.push_back('{0, 4'd7, 16'hFFFF, 16'h0000, 16'h1234, 12, 4, 4, 298, 36, 16, 16'hEDCB});
`endif
    vecs.push_back('{1, 4'd2, 16'h0000, 16'h0000, 16'h0005,  6, 4, 2,  56, 12,  4, 16'h0005});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mode", mode1, 0);
    checkOutput("reset_str",  str1,  0);
    checkOutput("reset_busy", busy1, 0);
    checkOutput("reset_done", done1, 0);
    checkOutput("reset_err",  err1,  0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b0, 0);

    $display("[TB] back-to-back with ignored starts");
    applyStimulus(vecs[0], 1'b1, 0);
    applyStimulus(vecs[4], 1'b0, 0);

    $display("[TB] reset mid-transfer");
    applyStimulus(vecs[2], 1'b0, 20);
    applyStimulus(vecs[0], 1'b0, 0);

`ifdef SAM_TX_KEY_CHECK_EN
    begin
      int modeSeen, busySeen, errCount;
      $display("[TB] oversize key rejection");
      @(negedge clk);
      keyN = 4'd7; keyD = 16'hFFFF; keyCapN = 16'h0000; msgIn = 16'h1234; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      checkOutput("reject_busy_k", busy1, 0);
      checkOutput("reject_err_k", err1, 0);
      @(posedge clk); #1;
      checkOutput("reject_err_k1", err1, 1);
      modeSeen = 0; busySeen = 0; errCount = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (mode1 !== 1'b0 || str1 !== 1'b0) modeSeen++;
        if (busy1 !== 1'b0) busySeen++;
        if (err1 !== 1'b0) errCount++;
      end
      checkOutput("reject_mode_quiet", modeSeen, 0);
      checkOutput("reject_busy_quiet", busySeen, 0);
      checkOutput("reject_err_single", errCount, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
